// File: rtl/field_scanner.sv
// field_scanner
// Frame sequencer for the metaball array. For each frame it walks every pixel
// in row-major order, strobes all balls with the pixel coordinate, waits for
// all of them to finish, sums their Q16.15 contributions with saturation,
// thresholds the sum and writes one bit per pixel to the frame buffer. After
// the last pixel it pulses the balls' move enable.
//
// Optional feature: define FIELD_SCANNER_WDT_EN to add a WAIT watchdog that
// forces a dark pixel and sets a sticky o_err after WDT_CYCLES cycles.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_frame_start   one-cycle request to render a frame (ignored while busy)
//   o_px_stb        pixel strobe to all balls
//   o_p_x, o_p_y    pixel coordinate, Q16.15
//   i_vld           per-ball completion flags
//   i_contrib       per-ball contributions, ball i at [32i+31:32i]
//   o_wr_en         frame-buffer write strobe
//   o_wr_addr       write address, y*COLS + x
//   o_wr_data       pixel lit (sum >= THRESH)
//   o_mov_en        one-cycle position-update pulse
//   o_busy          high from frame acceptance until o_mov_en
//   o_err           sticky watchdog flag (0 without the watchdog)
//
// state  | meaning
// IDLE   | waiting for i_frame_start
// ISSUE  | o_px_stb high for the current pixel
// SETTLE | one cycle where stale i_vld from the previous pixel is ignored
// WAIT   | waiting for all i_vld bits high
// WRITE  | o_wr_en high, coordinates advance
// MOVE   | last pixel written, o_mov_en issued next
module field_scanner #(
  parameter int          N_BALLS    = 4,
  parameter int          COLS       = 32,
  parameter int          ROWS       = 64,
  parameter logic [31:0] THRESH     = 32'h0000_8000,
  parameter int          WDT_CYCLES = 255,
  localparam int         AW         = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_frame_start,
  output logic                   o_px_stb,
  output logic [31:0]            o_p_x,
  output logic [31:0]            o_p_y,
  input  logic [N_BALLS-1:0]     i_vld,
  input  logic [32*N_BALLS-1:0]  i_contrib,
  output logic                   o_wr_en,
  output logic [AW-1:0]          o_wr_addr,
  output logic                   o_wr_data,
  output logic                   o_mov_en,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_WRITE, S_MOVE
  } state_t;

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic [34:0]   w_sum;
  logic [31:0]   w_sat;
  logic          w_done;
  logic          w_last;
  logic          w_wdt_to;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic [AW-1:0] w_addr;

  // 35 bits holds the sum of up to 8 full-scale words without overflow.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_BALLS; i++)
      w_sum = w_sum + {3'b000, i_contrib[32*i +: 32]};
    w_sat = (|w_sum[34:32]) ? 32'hFFFF_FFFF : w_sum[31:0];
  end

  always_comb begin
    w_done = &i_vld;
    w_last = (r_x == X_LAST) && (r_y == Y_LAST);
    w_addr = AW'(r_y) * AW'(COLS) + AW'(r_x);
    if (r_x == X_LAST) begin
      w_nx = '0;
      w_ny = r_y + 1'b1;
    end else begin
      w_nx = r_x + 1'b1;
      w_ny = r_y;
    end
  end

`ifdef FIELD_SCANNER_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] r_wdt;
  logic          r_err;

  // Counter holds the number of WAIT cycles already spent without completion.
  assign w_wdt_to = (r_wdt == WW'(WDT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_SETTLE)
        r_wdt <= '0;
      else if (r_state == S_WAIT && !w_done)
        r_wdt <= r_wdt + 1'b1;
      if (r_state == S_WAIT && !w_done && w_wdt_to)
        r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  // No watchdog: WAIT blocks until completion. The parameter stays referenced
  // so both builds share one parameter list without unused-parameter noise.
  assign w_wdt_to = 1'b0 && (WDT_CYCLES > 0);
  assign o_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      o_px_stb  <= 1'b0;
      o_p_x     <= '0;
      o_p_y     <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= 1'b0;
      o_mov_en  <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_px_stb <= 1'b0;
      o_wr_en  <= 1'b0;
      o_mov_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_frame_start) begin
            r_x      <= '0;
            r_y      <= '0;
            o_p_x    <= '0;
            o_p_y    <= '0;
            o_px_stb <= 1'b1;
            o_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE:  r_state <= S_SETTLE;
        S_SETTLE: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_done || w_wdt_to) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= w_addr;
            o_wr_data <= w_done && (w_sat >= THRESH);
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_last) begin
            r_x     <= '0;
            r_y     <= '0;
            r_state <= S_MOVE;
          end else begin
            r_x      <= w_nx;
            r_y      <= w_ny;
            o_p_x    <= 32'(w_nx) << 15;
            o_p_y    <= 32'(w_ny) << 15;
            o_px_stb <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_MOVE: begin
          o_mov_en <= 1'b1;
          o_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/field_scanner.md
# field_scanner

Frame sequencer and accumulator that drives the pixel-request side of the metaball array. Once per frame it walks every pixel of the display in row-major order, strobes all metaball instances with the pixel coordinate, and waits for every instance to report completion. It then sums their Q16.15 contributions with saturation, thresholds the sum, and writes one bit per pixel into the frame buffer. After the last pixel it pulses the metaballs' move enable.

## Interface

Parameters:
- `N_BALLS`, 4: number of metaball instances served (1..8).
- `COLS`, 32: display width in pixels.
- `ROWS`, 64: display height in pixels.
- `THRESH`, 32'h0000_8000: Q16.15 iso-threshold (1.0); pixel lit when sum >= THRESH.
- `WDT_CYCLES`, 255: watchdog limit in cycles (used only with the macro).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `frame_start`, in, 1: one-cycle request to render a frame.
- `px_stb`, out, 1: pixel strobe to all metaballs.
- `p_x`, out, 32: pixel x as Q16.15 (x << 15), held stable from px_stb until the write.
- `p_y`, out, 32: pixel y as Q16.15 (y << 15), same hold rule.
- `vld`, in, N_BALLS: per-ball completion flags.
- `contrib`, in, 32*N_BALLS: per-ball contributions; ball i is at bits [32i+31:32i].
- `wr_en`, out, 1: frame-buffer write strobe.
- `wr_addr`, out, clog2(COLS*ROWS): write address, y*COLS + x.
- `wr_data`, out, 1: pixel lit.
- `mov_en`, out, 1: one-cycle position-update pulse to the metaballs.
- `busy`, out, 1: high from frame acceptance until mov_en.
- `err`, out, 1: sticky watchdog flag (tied 0 without the macro).

## Operation

- States: IDLE, ISSUE, SETTLE, WAIT, WRITE, MOVE.
- IDLE:
  - On `frame_start`, set x = 0 and y = 0, assert `busy`, go to ISSUE.
  - `frame_start` while not in IDLE is ignored.
- ISSUE:
  - Hold `px_stb` = 1 for exactly one cycle with the current `p_x`/`p_y`.
  - Go to SETTLE.
- SETTLE:
  - One cycle in which `vld` is ignored. Metaball `vld` stays high from the previous pixel until its divider restarts.
  - Go to WAIT.
- WAIT:
  - Stay until `&vld` == 1.
  - In that cycle, register the sum of all `contrib` words, treated as unsigned 32-bit, and go to WRITE.
  - The sum uses a 35-bit intermediate and saturates to 32'hFFFF_FFFF.
- WRITE:
  - Assert `wr_en` for one cycle with `wr_data` = (sum >= THRESH) and `wr_addr` = y*COLS + x.
  - Then advance: x increments; at x = COLS-1, x wraps to 0 and y increments.
  - If the written pixel was (COLS-1, ROWS-1), go to MOVE; otherwise go to ISSUE.
- MOVE:
  - Assert `mov_en` for one cycle, deassert `busy`, go to IDLE.
- Reset, including mid-frame:
  - State returns to IDLE; x and y go to 0.
  - All outputs go to 0: `px_stb`, `p_x`, `p_y`, `wr_en`, `wr_addr`, `wr_data`, `mov_en`, `busy`, `err`.
  - No partial `mov_en` is issued.
- `mov_en` never coincides with `px_stb` or WAIT, so ball positions are constant across a frame.

## Timing

- Outputs are registered.
- `px_stb` is high in the cycle after entry to ISSUE is decided.
- `frame_start` at cycle 0 gives `px_stb` for pixel (0,0) at cycle 1.
- Per pixel, let L be the cycles from `px_stb` high to the edge on which `&vld` is sampled high (L >= 2). The next `px_stb` follows L + 2 cycles after the current one: WAIT exit, WRITE, ISSUE.
- Frame length is COLS*ROWS*(L+2) + 2 cycles from `frame_start` to `mov_en`.
- `wr_en` and `px_stb` are never high in the same cycle.
- If `vld` bits rise on different cycles, completion is the cycle the last bit is seen high. A bit that drops again before all bits are high counts as not complete.

## Configuration

- `FIELD_SCANNER_WDT_EN` defined:
  - A WAIT counter starts at 0 on WAIT entry.
  - If it reaches `WDT_CYCLES` without `&vld`, go to WRITE with `wr_data` = 0 and set `err`.
  - `err` is sticky until `rst`. The scan continues normally.
- Undefined:
  - WAIT blocks indefinitely.
  - `err` is constant 0 and no counter is built.

## Test plan

Bench uses N_BALLS = 2, COLS = 4, ROWS = 2, and a stub ball model with fixed L = 5.

- Empty field: contributions all 0, one `frame_start` -> 8 writes at addresses 0..7, all `wr_data` = 0; one `mov_en` at cycle 8*7 + 2 = 58; `busy` low afterwards.
- Threshold edge: ball contributions 0x4000 + 0x4000 at pixel (2,1) and 0x4000 + 0x3FFF elsewhere -> only `wr_addr` = 6 writes 1.
- Saturation: both contributions 32'hFFFF_0000 -> sum saturates, `wr_data` = 1, no wraparound to 0.
- Stale vld: stub keeps `vld` high through ISSUE/SETTLE and drops it for 5 cycles -> scanner waits for the new rising `vld`; no write occurs before it.
- Skewed/reset: ball 1 `vld` 3 cycles later than ball 0 -> write occurs after ball 1. Separately, `rst` during pixel 3 WAIT -> all outputs 0 next cycle, no `mov_en`; a new `frame_start` restarts at address 0.
- Watchdog (with `FIELD_SCANNER_WDT_EN`, `WDT_CYCLES` = 10): ball 1 never asserts `vld` at pixel 2 -> `wr_data` = 0 at address 2 after 10 WAIT cycles, `err` = 1 and stays set, frame still ends with `mov_en`.
